ps2_tx: RTL

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync.sv | 28 ++
 rtl/ps2_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, timing defaults and frame constants
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAITREL
  } ps2_state_t;

  localparam int PS2_INHIBIT_CYC = 2500;
  localparam int PS2_TIMEOUT_CYC = 375000;
  localparam int PS2_FRAME_BITS  = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - 2-FF synchronizer with falling-edge detect for one PS/2 line
module ps2_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta, sync, prev;

  // Reset to the idle-high level so leaving reset never looks like an edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device byte transmitter (inhibit, request, shift, ack)
// Optional transfer watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps_clock_in,
  input  logic       ps_data_in,
  output logic       ps_clock_oe,
  output logic       ps_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  ps2_state_t state, state_d;
  logic [IW-1:0] inh_cnt, inh_cnt_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic [PS2_FRAME_BITS-2:0] frame, frame_d;
  logic data_oe_q, data_oe_d;
  logic done_d, err_d;
  logic clk_level, clk_fall, dat_level, unused_dat_fall;
  logic timeout;

  ps2_sync u_clk_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .line    (ps_clock_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_sync u_dat_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .line    (ps_data_in),
    .level   (dat_level),
    .fall    (unused_dat_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
  logic [WW-1:0] wd_cnt;

  // Zero throughout the inhibit phase, so it reads 0 on the first REQ cycle.
  always_ff @(posedge clock) begin
    if (!reset_n || state == IDLE || state == INHIBIT)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (state != IDLE) && (state != INHIBIT) && (wd_cnt == WD_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      data_oe_q <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      inh_cnt   <= inh_cnt_d;
      bit_cnt   <= bit_cnt_d;
      frame     <= frame_d;
      data_oe_q <= data_oe_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    inh_cnt_d   = inh_cnt;
    bit_cnt_d   = bit_cnt;
    frame_d     = frame;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    err_d       = err;
    ps_clock_oe = (state == INHIBIT) || (state == REQ);
    ps_data_oe  = data_oe_q;
    busy        = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          // Frame after the start bit, LSB first: data, parity, stop.
          frame_d   = {1'b1, odd_parity(data), data};
          err_d     = 1'b0;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          inh_cnt_d = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (clk_fall) begin
          data_oe_d = ~frame[bit_cnt];
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ACK;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          err_d   = dat_level;
          state_d = WAITREL;
        end
      end
      WAITREL: begin
        if (clk_level && dat_level) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      done_d    = 1'b1;
      state_d   = IDLE;
    end
  end

endmodule
